// File: rtl/lpddr_device_model.sv
// LPDDR device-side responder: command decode, per-bank open-row tracking,
// mode register (CL/BL), small burst storage and DQS-framed read returns.
module lpddr_device_model #(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned COL_BITS = 5
) (
    input  logic        WR_CLK_333M,
    input  logic        RESET,
    input  logic        CLK_PHASE,
    input  logic        CKE,
    input  logic        WE,
    input  logic        CAS,
    input  logic        RAS,
    input  logic [1:0]  BA,
    input  logic [12:0] ADDR_RAM,
    input  logic [1:0]  DM,
    input  logic [15:0] DQ_IN,
    input  logic        DQS_IN,
    output logic [15:0] DQ_OUT,
    output logic        DQ_OE,
    output logic        DQS_OUT,
    output logic        DQS_OE,
    output logic        INIT_DONE,
    output logic [3:0]  BANK_OPEN,
    output logic [3:0]  ERR
);

    localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [3:0] CMD_INIT  = 4'b1000;
    localparam logic [3:0] CMD_PRE   = 4'b1010;
    localparam logic [3:0] CMD_ACT   = 4'b1110;
    localparam logic [3:0] CMD_READ  = 4'b1101;
    localparam logic [3:0] CMD_WRITE = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cl_q, cl_d;
    logic [4:0]            bl_q, bl_d;
    logic [4:0]            beat_q, beat_d;
    logic [2:0]            wait_q, wait_d;
    logic [1:0]            burst_bank_q, burst_bank_d;
    logic [ROW_BITS-1:0]   burst_row_q, burst_row_d;
    logic [COL_BITS-1:0]   burst_col_q, burst_col_d;
    logic [12:0]           row_q [4];
    logic [12:0]           row_d [4];
    logic                  dqs_prev_q, dqs_prev_d;
    logic [15:0]           dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  dqs_out_q, dqs_out_d;
    logic                  dqs_oe_q, dqs_oe_d;
    logic                  init_done_q, init_done_d;
    logic [3:0]            bank_open_q, bank_open_d;
    logic [3:0]            err_q, err_d;

    logic [15:0]           mem [DEPTH];

    logic [3:0]            cmd_c;
    logic                  accept_c;
    logic                  busy_rd_c;
    logic [COL_BITS-1:0]   blm_c;
    logic [COL_BITS-1:0]   beat_col_c;
    logic [AW-1:0]         mem_idx_c;
    logic [15:0]           mem_rd_c;
    logic                  mem_we_c;

    // Storage addressing: current beat wraps inside the BL-aligned column block
    always_comb begin
        cmd_c      = {CKE, WE, CAS, RAS};
        accept_c   = CLK_PHASE && (cmd_c inside {CMD_INIT, CMD_PRE, CMD_ACT, CMD_READ, CMD_WRITE});
        busy_rd_c  = (state_q == ST_RD_WAIT) || (state_q == ST_RD_BURST);
        blm_c      = COL_BITS'(bl_q - 5'd1);
        beat_col_c = (burst_col_q & ~blm_c) | ((burst_col_q + COL_BITS'(beat_q)) & blm_c);
        mem_idx_c  = {burst_bank_q, burst_row_q, beat_col_c};
        mem_rd_c   = mem[mem_idx_c];
    end

    // Next-state: command execution, write capture and read burst sequencing
    always_comb begin
        state_d      = state_q;
        cl_d         = cl_q;
        bl_d         = bl_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        burst_bank_d = burst_bank_q;
        burst_row_d  = burst_row_q;
        burst_col_d  = burst_col_q;
        row_d        = row_q;
        dqs_prev_d   = DQS_IN;
        dq_out_d     = dq_out_q;
        dq_oe_d      = dq_oe_q;
        dqs_out_d    = dqs_out_q;
        dqs_oe_d     = dqs_oe_q;
        init_done_d  = init_done_q;
        bank_open_d  = bank_open_q;
        err_d        = err_q;
        mem_we_c     = 1'b0;

        if (busy_rd_c) begin
            // Read bursts are never interrupted; overlapping commands are flagged
            if (accept_c) begin
                err_d[3] = 1'b1;
            end
            if (state_q == ST_RD_WAIT) begin
                if (wait_q == 3'd1) begin
                    dqs_oe_d  = 1'b1;
                    dqs_out_d = 1'b0;
                end
                if (wait_q == 3'd0) begin
                    state_d   = ST_RD_BURST;
                    dq_oe_d   = 1'b1;
                    dq_out_d  = mem_rd_c;
                    dqs_out_d = 1'b1;
                    beat_d    = beat_q + 5'd1;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end else if (beat_q == bl_q) begin
                state_d   = ST_IDLE;
                dq_oe_d   = 1'b0;
                dq_out_d  = 16'h0000;
                dqs_oe_d  = 1'b0;
                dqs_out_d = 1'b0;
            end else begin
                dq_out_d  = mem_rd_c;
                dqs_out_d = ~dqs_out_q;
                beat_d    = beat_q + 5'd1;
            end
        end else if (accept_c) begin
            // Any accepted command also truncates an in-flight write burst
            state_d = ST_IDLE;
            if (cmd_c == CMD_INIT) begin
                init_done_d = 1'b1;
                if (ADDR_RAM[6:4] == 3'd2 || ADDR_RAM[6:4] == 3'd3) begin
                    cl_d = ADDR_RAM[5:4];
                end else begin
                    err_d[3] = 1'b1;
                end
                case (ADDR_RAM[2:0])
                    3'd1:    bl_d = 5'd2;
                    3'd2:    bl_d = 5'd4;
                    3'd3:    bl_d = 5'd8;
                    3'd4:    bl_d = 5'd16;
                    default: err_d[3] = 1'b1;
                endcase
            end else if (!init_done_q) begin
                err_d[0] = 1'b1;
            end else if (cmd_c == CMD_PRE) begin
                if (ADDR_RAM[10]) begin
                    bank_open_d = 4'b0000;
                end else begin
                    bank_open_d[BA] = 1'b0;
                end
            end else if (cmd_c == CMD_ACT) begin
                if (bank_open_q[BA]) begin
                    err_d[2] = 1'b1;
                end
                bank_open_d[BA] = 1'b1;
                row_d[BA]       = ADDR_RAM;
            end else if (!bank_open_q[BA]) begin
                err_d[1] = 1'b1;
            end else begin
                burst_bank_d = BA;
                burst_row_d  = row_q[BA][ROW_BITS-1:0];
                burst_col_d  = ADDR_RAM[COL_BITS-1:0];
                beat_d       = 5'd0;
                if (cmd_c == CMD_WRITE) begin
                    state_d = ST_WR_BURST;
                end else begin
                    state_d = ST_RD_WAIT;
                    wait_d  = 3'({cl_q, 1'b0}) - 3'd2;
                end
            end
        end else if (state_q == ST_WR_BURST && DQS_IN != dqs_prev_q) begin
            mem_we_c = 1'b1;
            beat_d   = beat_q + 5'd1;
            if (beat_q == bl_q - 5'd1) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers
    always_ff @(posedge WR_CLK_333M or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cl_q         <= 2'd3;
            bl_q         <= 5'd16;
            beat_q       <= 5'd0;
            wait_q       <= 3'd0;
            burst_bank_q <= 2'd0;
            burst_row_q  <= '0;
            burst_col_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= 13'd0;
            end
            dqs_prev_q   <= 1'b0;
            dq_out_q     <= 16'h0000;
            dq_oe_q      <= 1'b0;
            dqs_out_q    <= 1'b0;
            dqs_oe_q     <= 1'b0;
            init_done_q  <= 1'b0;
            bank_open_q  <= 4'b0000;
            err_q        <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cl_q         <= cl_d;
            bl_q         <= bl_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            burst_bank_q <= burst_bank_d;
            burst_row_q  <= burst_row_d;
            burst_col_q  <= burst_col_d;
            row_q        <= row_d;
            dqs_prev_q   <= dqs_prev_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            dqs_out_q    <= dqs_out_d;
            dqs_oe_q     <= dqs_oe_d;
            init_done_q  <= init_done_d;
            bank_open_q  <= bank_open_d;
            err_q        <= err_d;
        end
    end

    // Byte-masked storage write; contents survive reset
    always_ff @(posedge WR_CLK_333M) begin
        if (mem_we_c) begin
            if (!DM[0]) begin
                mem[mem_idx_c][7:0] <= DQ_IN[7:0];
            end
            if (!DM[1]) begin
                mem[mem_idx_c][15:8] <= DQ_IN[15:8];
            end
        end
    end

    assign DQ_OUT    = dq_out_q;
    assign DQ_OE     = dq_oe_q;
    assign DQS_OUT   = dqs_out_q;
    assign DQS_OE    = dqs_oe_q;
    assign INIT_DONE = init_done_q;
    assign BANK_OPEN = bank_open_q;
    assign ERR       = err_q;

endmodule
